// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared constants and state encoding for the configuration-chain bitstream loader.
// Defaults match the fabric's ccff_head width and chain depth.
package ccff_bitstream_loader_pkg;

    localparam int DEF_NUM_CHAINS   = 12;
    localparam int DEF_CHAIN_LEN    = 1024;
    localparam int DEF_RESET_CYCLES = 4;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_PRESET = 3'd1;
    localparam logic [STATE_W-1:0] ST_LOAD   = 3'd2;
    localparam logic [STATE_W-1:0] ST_SETUP  = 3'd3;
    localparam logic [STATE_W-1:0] ST_PULSE  = 3'd4;
    localparam logic [STATE_W-1:0] ST_FINISH = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_PRESET = 3'd1,
        S_LOAD   = 3'd2,
        S_SETUP  = 3'd3,
        S_PULSE  = 3'd4,
        S_FINISH = 3'd5
    } state_e;

    // config_enable and busy are both asserted across this span of states
    function automatic logic in_cfg_phase(input logic [STATE_W-1:0] state);
        return (state == ST_PRESET) || (state == ST_LOAD) ||
               (state == ST_SETUP)  || (state == ST_PULSE);
    endfunction

endpackage

// File: rtl/ccff_bitstream_loader.sv
// Streams a bitstream into the fabric's parallel config chains via a generated prog_clk, returning displaced bits.
// 3 clk per bit minimum (LOAD/SETUP/PULSE); cfg_ready only in LOAD, so the source stalls the FSM indefinitely.
module ccff_bitstream_loader
    import ccff_bitstream_loader_pkg::*;
#(
    parameter int NUM_CHAINS   = DEF_NUM_CHAINS,
    parameter int CHAIN_LEN    = DEF_CHAIN_LEN,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [0:NUM_CHAINS-1] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [0:NUM_CHAINS-1] tail_data,
    output logic                  tail_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  pReset,
    output logic                  config_enable,
    output logic                  prog_clk,
    output logic [0:NUM_CHAINS-1] ccff_head,
    input  logic [0:NUM_CHAINS-1] ccff_tail
);

    localparam int BIT_W = $clog2(CHAIN_LEN + 1);
    localparam int RST_W = $clog2(RESET_CYCLES + 1);

    logic [STATE_W-1:0]    r_state;
    logic [RST_W-1:0]      r_rst_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;

    logic                  r_p_reset;
    logic                  r_cfg_en;
    logic                  r_busy;
    logic                  r_prog_clk;
    logic                  r_tail_vld;
    logic                  r_done;
    logic [0:NUM_CHAINS-1] r_head;
    logic [0:NUM_CHAINS-1] r_tail;

    logic [STATE_W-1:0]    w_nxt_state;
    logic                  w_accept;
    logic                  w_preset_last;
    logic                  w_last_bit;

    assign w_preset_last = (r_rst_cnt == RST_W'(1));
    assign w_last_bit    = (r_bit_cnt == BIT_W'(CHAIN_LEN - 1));

    always_comb begin
        w_nxt_state = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_nxt_state = ST_PRESET;
                end
            end
            ST_PRESET: begin
                if (w_preset_last) begin
                    w_nxt_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cfg_valid) begin
                    w_nxt_state = ST_SETUP;
                    w_accept    = 1'b1;
                end
            end
            ST_SETUP: begin
                w_nxt_state = ST_PULSE;
            end
            ST_PULSE: begin
                w_nxt_state = w_last_bit ? ST_FINISH : ST_LOAD;
            end
            ST_FINISH: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
        // abort beats every other transition; in IDLE it simply keeps us there
        if (abort) begin
            w_nxt_state = ST_IDLE;
            w_accept    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_rst_cnt <= RST_W'(RESET_CYCLES);
                r_bit_cnt <= '0;
            end else begin
                if ((r_state == ST_PRESET) && (r_rst_cnt != '0)) begin
                    r_rst_cnt <= r_rst_cnt - RST_W'(1);
                end
                if (r_state == ST_PULSE) begin
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                end
            end
        end
    end

    // Control outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p_reset  <= 1'b0;
            r_cfg_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_prog_clk <= 1'b0;
            r_tail_vld <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_p_reset  <= (w_nxt_state == ST_PRESET);
            r_cfg_en   <= in_cfg_phase(w_nxt_state);
            r_busy     <= in_cfg_phase(w_nxt_state);
            r_prog_clk <= (w_nxt_state == ST_PULSE);
            r_tail_vld <= (w_nxt_state == ST_PULSE);
            r_done     <= (w_nxt_state == ST_FINISH);
        end
    end

    // Head moves only when a beat is taken in LOAD, so it is stable through SETUP, PULSE and the cycle after.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (w_nxt_state == ST_IDLE) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_accept) begin
                r_head <= cfg_data;
            end
            if (r_state == ST_SETUP) begin
                r_tail <= ccff_tail;
            end
        end
    end

    assign cfg_ready     = (r_state == ST_LOAD);
    assign tail_data     = r_tail;
    assign tail_valid    = r_tail_vld;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pReset        = r_p_reset;
    assign config_enable = r_cfg_en;
    assign prog_clk      = r_prog_clk;
    assign ccff_head     = r_head;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: table-driven control sequence plus randomized loads
// against a behavioural fabric and a position-queue model of chain contents.
module tb_ccff_bitstream_loader;

    localparam int NC       = 12;
    localparam int CL       = 8;
    localparam int RC       = 4;
    localparam int FULL_CYC = 1 + RC + 3 * CL + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [0:NC-1] cfg_data = '0;
    logic          cfg_ready;
    logic [0:NC-1] tail_data;
    logic          tail_valid, busy, done, pReset, config_enable, prog_clk;
    logic [0:NC-1] ccff_head;
    logic [0:NC-1] ccff_tail;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ccff_bitstream_loader #(
        .NUM_CHAINS  (NC),
        .CHAIN_LEN   (CL),
        .RESET_CYCLES(RC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .tail_data    (tail_data),
        .tail_valid   (tail_valid),
        .busy         (busy),
        .done         (done),
        .pReset       (pReset),
        .config_enable(config_enable),
        .prog_clk     (prog_clk),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail)
    );

    // Behavioural fabric: each chain shifts head -> position 1 .. position CL -> tail on prog_clk rise.
    logic [CL-1:0] seed [NC];
    logic [CL-1:0] fab  [NC];
    logic          fab_load = 1'b0;

    always @(posedge prog_clk or posedge fab_load) begin
        for (int c = 0; c < NC; c++) begin
            if (fab_load) fab[c] <= seed[c];
            else          fab[c] <= {fab[c][CL-2:0], ccff_head[c]};
        end
    end

    always_comb begin
        ccff_tail = '0;
        for (int c = 0; c < NC; c++) ccff_tail[c] = fab[c][CL-1];
    end

    // Expected chain contents: exp_q[p-1] is the word at chain position p.
    logic [0:NC-1] exp_q [$];

    task automatic model_shift(input logic [0:NC-1] h);
        exp_q.push_front(h);
        void'(exp_q.pop_back());
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [30:0] all_outs();
        return {cfg_ready, tail_data, tail_valid, busy, done, pReset,
                config_enable, prog_clk, ccff_head};
    endfunction

    typedef struct {
        logic          st;
        logic          ab;
        logic          vl;
        logic [0:NC-1] dat;
        logic [6:0]    flags;  // pReset, config_enable, busy, cfg_ready, prog_clk, tail_valid, done
        logic [0:NC-1] head;
    } vec_t;

    vec_t tbl [13];

    task automatic run_load(input string nm, input int pat, input int stall_at,
                            input int abort_at, input bit rand_valid, input int exp_done);
        logic [0:NC-1] beats [CL];
        logic [0:NC-1] prev_head;
        int  nacc, npulse, cyc, npre, ndone, done_cyc, last_pulse, stall_left, nbad;
        bit  take, was_stall, aborting, fin, prev_pc;
        bit  bad_period, bad_tv, bad_stable, bad_hold, bad_after;
        nacc = 0; npulse = 0; cyc = 1; npre = 0; ndone = 0; done_cyc = 0;
        last_pulse = 0; stall_left = 5; nbad = 0;
        fin = 0; prev_pc = 0; prev_head = '0;
        bad_period = 0; bad_tv = 0; bad_stable = 0; bad_hold = 0; bad_after = 0;
        for (int k = 0; k < CL; k++)
            beats[k] = (pat == 0) ? {3{4'(k)}} : NC'($urandom);

        @(negedge clk);
        start     = 1'b1;
        cfg_valid = !rand_valid || ($urandom_range(0, 1) == 1);
        cfg_data  = beats[0];
        for (int t = 0; t < 3000 && !fin; t++) begin
            take      = cfg_ready && cfg_valid;
            was_stall = cfg_ready && !cfg_valid;
            aborting  = abort;
            @(posedge clk);
            if (take) nacc++;
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (aborting) begin
                chk({nm, " abort_clears_outputs"}, 64'(all_outs()), 64'd0);
                abort = 1'b0;
                fin   = 1'b1;
            end else begin
                if (pReset) npre++;
                if (prog_clk) begin
                    if (npulse < CL) begin
                        chk({nm, " head_at_pulse"}, 64'(ccff_head), 64'(beats[npulse]));
                        chk({nm, " tail_beat"}, 64'({tail_valid, tail_data}), 64'({1'b1, exp_q[CL-1]}));
                        model_shift(beats[npulse]);
                    end else begin
                        bad_period = 1'b1;
                    end
                    if (prev_pc || (last_pulse > 0 && cyc - last_pulse < 3)) bad_period = 1'b1;
                    last_pulse = cyc;
                    npulse++;
                    if (npulse == abort_at) abort = 1'b1;
                end else if (tail_valid) begin
                    bad_tv = 1'b1;
                end
                if (prev_pc && ccff_head !== prev_head) bad_stable = 1'b1;
                if (was_stall && (!cfg_ready || prog_clk ||
                    (nacc > 0 && ccff_head !== beats[nacc-1]))) bad_hold = 1'b1;
                if (done) begin
                    ndone++;
                    done_cyc = cyc;
                    chk({nm, " done_flags"}, 64'({busy, config_enable}), 64'd0);
                    fin = 1'b1;
                end
                prev_pc   = prog_clk;
                prev_head = ccff_head;
                if (stall_at >= 0 && nacc == stall_at && stall_left > 0 && cfg_ready) begin
                    cfg_valid = 1'b0;
                    stall_left--;
                end else if (rand_valid) begin
                    cfg_valid = ($urandom_range(0, 2) != 0);
                end else begin
                    cfg_valid = 1'b1;
                end
                cfg_data = (cfg_valid && nacc < CL) ? beats[nacc] : NC'($urandom);
            end
        end
        cfg_valid = 1'b0;
        if (!fin) chk({nm, " timeout"}, 64'd0, 64'd1);

        if (abort_at > 0) begin
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (done || busy || prog_clk || pReset) bad_after = 1'b1;
            end
            chk({nm, " no_done_after_abort"}, 64'({ndone, 31'(bad_after)}), 64'd0);
        end else begin
            chk({nm, " prog_clk_pulses"}, 64'(npulse), 64'(CL));
            chk({nm, " preset_cycles"}, 64'(npre), 64'(RC));
            chk({nm, " done_count"}, 64'(ndone), 64'd1);
            if (exp_done > 0) chk({nm, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
            if (stall_at >= 0) chk({nm, " stall_cycles_used"}, 64'(stall_left), 64'd0);
            // first accepted beat sits deepest: position p holds beat CL-p
            for (int c = 0; c < NC; c++)
                for (int p = 1; p <= CL; p++)
                    if (fab[c][p-1] !== beats[CL-p][c]) nbad++;
            chk({nm, " chain_contents"}, 64'(nbad), 64'd0);
        end
        chk({nm, " timing_flags"}, 64'({bad_period, bad_tv, bad_stable, bad_hold}), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [0:NC-1] w;
        for (int c = 0; c < NC; c++) seed[c] = CL'($urandom);
        for (int p = 0; p < CL; p++) begin
            for (int c = 0; c < NC; c++) w[c] = seed[c][p];
            exp_q.push_back(w);
        end
        #1 fab_load = 1'b1;
        #1 fab_load = 1'b0;

        // reset held with start high: every output stays at 0
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero", 64'(all_outs()), 64'd0);
        start   = 1'b0;
        reset_n = 1'b1;

        //            st    ab    vl    dat       pR ce bz rdy pc tv dn   head
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 12'h000, 7'b0000000, 12'h000}; // start+abort in IDLE
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 12'h000, 7'b0000000, 12'h000}; // abort in IDLE
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 12'h000, 7'b1110000, 12'h000}; // PRESET 1
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 12'h000, 7'b1110000, 12'h000}; // PRESET 2, start ignored
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 12'h000, 7'b1110000, 12'h000}; // PRESET 3
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 12'h000, 7'b1110000, 12'h000}; // PRESET 4
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 12'h000, 7'b0111000, 12'h000}; // LOAD
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 12'h000, 7'b0111000, 12'h000}; // LOAD held, start ignored
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 12'hA5C, 7'b0110000, 12'hA5C}; // SETUP
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 12'h3F0, 7'b0110110, 12'hA5C}; // PULSE, data not consumed
        tbl[10] = '{1'b0, 1'b0, 1'b0, 12'h000, 7'b0111000, 12'hA5C}; // back to LOAD
        tbl[11] = '{1'b0, 1'b1, 1'b0, 12'h000, 7'b0000000, 12'h000}; // abort
        tbl[12] = '{1'b0, 1'b0, 1'b0, 12'h000, 7'b0000000, 12'h000}; // stays IDLE

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            start     = tbl[i].st;
            abort     = tbl[i].ab;
            cfg_valid = tbl[i].vl;
            cfg_data  = tbl[i].dat;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("table_vec%0d", i),
                64'({pReset, config_enable, busy, cfg_ready, prog_clk, tail_valid, done, ccff_head}),
                64'({tbl[i].flags, tbl[i].head}));
        end
        start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
        model_shift(12'hA5C);

        run_load("idx_pattern",  0, -1, 0, 1'b0, FULL_CYC);
        run_load("pattern_b",    1, -1, 0, 1'b0, FULL_CYC);
        run_load("backpressure", 1,  4, 0, 1'b0, FULL_CYC + 5);
        run_load("abort_bit3",   1, -1, 3, 1'b0, 0);
        run_load("fresh_load",   1, -1, 0, 1'b0, FULL_CYC);
        for (int r = 0; r < 3; r++)
            run_load($sformatf("rand_valid%0d", r), 1, -1, 0, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
